onehot_decoder_seq: RTL and testbench

//  Sequenced 2-to-4 one-hot decoder; inverse of the team's 4-to-2 priority encoder.

---
 rtl/onehot_decoder_seq.sv | 152 +++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq -- sequenced 2-to-4 one-hot decoder.
//
// Takes a 2-bit code over a valid/ready handshake. It drives onehot[code]
// for HOLD_CYCLES cycles, then holds all lines low for GAP_CYCLES cycles,
// then returns to IDLE. Two lines are never high in the same cycle, so
// loads that share a bus (digit enables, row selects) cannot ghost.
//
// Parameters:
//   HOLD_CYCLES  cycles the decoded line stays high (>=1)
//   GAP_CYCLES   blanking cycles after the hold (>=0)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   code        code to decode, sampled on the handshake edge
//   code_valid  request; code must be stable while it is high
//   code_ready  high in IDLE (taken from the state flop only)
//   onehot      registered decoded lines
//   active      high while a line is driven (|onehot)
//   done        one-cycle pulse on the first IDLE cycle after a request
//
// Optional build macro ONEHOT_DECODER_SCAN_EN: with no request in IDLE,
// the block issues scan_ptr itself and scan_ptr steps 0,1,2,3,0... No done
// pulse is produced for these self-issued codes.
module onehot_decoder_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [3:0] onehot,
  output logic       active,
  output logic       done
);

  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ?
                        ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2) :
                        ((GAP_CYCLES  > 2) ? GAP_CYCLES  : 2);
  localparam int CW = $clog2(CMAX);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    code_q, code_d;
  logic [3:0]    onehot_q, onehot_d;
  logic          done_q, done_d;
  logic          ext_flag;  // current job came from the handshake

`ifdef ONEHOT_DECODER_SCAN_EN
  logic [1:0] scan_q, scan_d;
  logic       ext_q, ext_d;
  assign ext_flag = ext_q;
`else
  assign ext_flag = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
`ifdef ONEHOT_DECODER_SCAN_EN
    scan_d  = scan_q;
    ext_d   = ext_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (code_valid) begin
          state_d = S_DRIVE;
          cnt_d   = HOLD_LD;
          code_d  = code;
`ifdef ONEHOT_DECODER_SCAN_EN
          ext_d   = 1'b1;
        end else begin
          // An external request in the same cycle takes priority and
          // leaves scan_ptr where it is.
          state_d = S_DRIVE;
          cnt_d   = HOLD_LD;
          code_d  = scan_q;
          scan_d  = scan_q + 2'd1;
          ext_d   = 1'b0;
`endif
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = S_IDLE;
            done_d  = ext_flag;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = ext_flag;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Decode from the next state so onehot is a flop that matches DRIVE
    // exactly, with no combinational decode on the output pins.
    onehot_d = (state_d == S_DRIVE) ? (4'b0001 << code_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      code_q   <= 2'd0;
      onehot_q <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
    end
  end

`ifdef ONEHOT_DECODER_SCAN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q <= 2'd0;
      ext_q  <= 1'b0;
    end else begin
      scan_q <= scan_d;
      ext_q  <= ext_d;
    end
  end
`endif

  assign code_ready = (state_q == S_IDLE);
  assign onehot     = onehot_q;
  assign active     = |onehot_q;
  assign done       = done_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
module tb_onehot_decoder_seq;

  localparam int HOLD [2] = '{4, 1};
  localparam int GAP  [2] = '{1, 0};
`ifdef ONEHOT_DECODER_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] cd  [2];
  logic       vl  [2];
  logic       rdy [2];
  logic [3:0] oh  [2];
  logic       act [2];
  logic       dn  [2];

  always #5 clk = ~clk;

  onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .code(cd[0]), .code_valid(vl[0]),
    .code_ready(rdy[0]), .onehot(oh[0]), .active(act[0]), .done(dn[0]));

  onehot_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .code(cd[1]), .code_valid(vl[1]),
    .code_ready(rdy[1]), .onehot(oh[1]), .active(act[1]), .done(dn[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each request is described by the edge it was taken
  // on, its code and its origin. Expected outputs come from the cycle
  // distance to that edge.
  int         n;
  int         t_acc    [2];
  logic [1:0] c_acc    [2];
  bit         has      [2];
  bit         ext_acc  [2];
  bit         e_rdy    [2];
  bit         pend     [2];
  bit         pend_ext [2];
  logic [1:0] pend_code[2];
  logic [1:0] sptr     [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has[i] = 0; e_rdy[i] = 1; pend[i] = 0; sptr[i] = 2'd0;
    end
  endtask

  // One clock: schedule the transfer decided by the inputs, advance, check.
  task automatic cyc(input bit v0, input logic [1:0] c0, input bit v1, input logic [1:0] c1);
    vl[0] = v0; cd[0] = c0; vl[1] = v1; cd[1] = c1;
    for (int i = 0; i < 2; i++) begin
      if (e_rdy[i] && vl[i]) begin
        pend[i] = 1; pend_code[i] = cd[i]; pend_ext[i] = 1;
      end else if (e_rdy[i] && SCAN) begin
        pend[i] = 1; pend_code[i] = sptr[i]; pend_ext[i] = 0;
        sptr[i] = sptr[i] + 2'd1;
      end
    end
    @(posedge clk);
    n++;
    for (int i = 0; i < 2; i++)
      if (pend[i]) begin
        has[i] = 1; t_acc[i] = n; c_acc[i] = pend_code[i];
        ext_acc[i] = pend_ext[i]; pend[i] = 0;
      end
    #1;
    for (int i = 0; i < 2; i++) begin
      int k;
      logic [3:0] e_oh;
      bit e_dn;
      int y;
      k     = n - t_acc[i];
      e_oh  = (has[i] && k < HOLD[i]) ? (4'b0001 << c_acc[i]) : 4'b0000;
      e_rdy[i] = !has[i] || (k >= HOLD[i] + GAP[i]);
      e_dn  = has[i] && ext_acc[i] && (k == HOLD[i] + GAP[i]);
      chk($sformatf("onehot%0d", i), 32'(oh[i]), 32'(e_oh));
      chk($sformatf("active%0d", i), 32'(act[i]), 32'(e_oh != 4'b0000));
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(e_rdy[i]));
      chk($sformatf("done%0d", i), 32'(dn[i]), 32'(e_dn));
      chk($sformatf("ones_le1_%0d", i), 32'($countones(oh[i]) <= 1), 32'd1);
      if (e_oh != 4'b0000) begin
        y = 0;
        for (int j = 0; j < 4; j++) if (oh[i][j]) y = j;
        chk($sformatf("enc_rt%0d", i), 32'(y), 32'(c_acc[i]));
      end
    end
  endtask

  initial begin
    n = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin vl[i] = 0; cd[i] = 2'd0; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_onehot", 32'(oh[0]), 32'd0);
    chk("rst_ready",  32'(rdy[0]), 32'd1);
    chk("rst_done",   32'(dn[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with no request.
    repeat (4) cyc(0, 2'd0, 0, 2'd0);

    // Code 3 on the default instance, then all codes on both.
    cyc(1, 2'd3, 0, 2'd0);
    repeat (7) cyc(0, 2'd0, 0, 2'd0);
    for (int c = 0; c < 4; c++) begin
      cyc(1, 2'(c), 1, 2'(c));
      repeat (6) cyc(0, 2'd0, 0, 2'd0);
    end

    // Valid held high while busy, code moves 1 -> 2; back-to-back 0,1 on
    // the zero-gap instance.
    cyc(1, 2'd1, 1, 2'd0);
    cyc(1, 2'd2, 1, 2'd1);
    repeat (8) cyc(1, 2'd2, 1, 2'd1);
    repeat (6) cyc(0, 2'd0, 0, 2'd0);

    // Reset in the middle of a drive of code 2.
    cyc(1, 2'd2, 1, 2'd2);
    cyc(0, 2'd0, 0, 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_onehot", 32'(oh[0]), 32'd0);
    chk("abort_active", 32'(act[0]), 32'd0);
    chk("abort_done",   32'(dn[0]), 32'd0);
    chk("abort_ready",  32'(rdy[0]), 32'd1);
    model_reset();
    for (int i = 0; i < 2; i++) begin vl[i] = 0; cd[i] = 2'd0; end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cyc(0, 2'd0, 0, 2'd0);

    // Random traffic.
    for (int r = 0; r < 500; r++)
      cyc($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
